wb_ram_slave: RTL and testbench

Wishbone classic-cycle slave: a word-addressed, byte-writable RAM with a programmable number of wait states and ERR/RTY signalling. It is the responder counterpart to the `wb_mast` bus-functional initiator. It sits on the SoC Wishbone fabric as scratch memory and as the reference target for exercising master-side ACK/ERR/RTY handling.

---
 rtl/wb_ram_slave_pkg.sv | 39 +++
 rtl/wb_ram_slave_mem.sv | 52 +++++
 rtl/wb_ram_slave.sv | 145 ++++++++++++++
 tb/tb_wb_ram_slave.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_ram_slave_pkg.sv
// rtl/wb_ram_slave_pkg.sv - shared types and helpers for the wb_ram_slave block
//
// Purpose : FSM state encoding, termination codes and the termination
//           classifier shared by the top level.
// Ports   : none (package).
package wb_ram_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    TERM_NONE = 2'd0,
    TERM_ACK  = 2'd1,
    TERM_ERR  = 2'd2,
    TERM_RTY  = 2'd3
  } term_e;

  localparam int unsigned MAX_WAIT_STATES = 15;

  // Retry outranks error, error outranks acknowledge.
  function automatic term_e classify(
    input logic       busy,
    input logic       in_range,
    input logic [1:0] adr_lo,
    input logic [3:0] sel
  );
    if (busy) begin
      return TERM_RTY;
    end
    if (!in_range || (adr_lo != 2'b00) || (sel == 4'b0000)) begin
      return TERM_ERR;
    end
    return TERM_ACK;
  endfunction

endpackage

// File: rtl/wb_ram_slave_mem.sv
// rtl/wb_ram_slave_mem.sv - single-port byte-writable RAM with registered read
//
// Purpose : 2^ADDR_WIDTH x 32-bit storage. Writes honour four byte enables.
//           The read register only loads when re_i is high, so it holds its
//           value between reads and doubles as the bus read-data output.
// Ports   : clk_i, rst_i (sync, active-high, clears only the read register),
//           addr_i word address, we_i/be_i/wdata_i write port,
//           re_i read enable, rdata_o registered read data.
module wb_ram_slave_mem #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  input  logic                  re_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] ram_array [0:(1<<ADDR_WIDTH)-1];
  logic [31:0] rd_data_q;
  logic [31:0] rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (re_i) begin
      rd_data_d = ram_array[addr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= 32'h0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i && be_i[b]) begin
        ram_array[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = rd_data_q;

endmodule

// File: rtl/wb_ram_slave.sv
// rtl/wb_ram_slave.sv - Wishbone classic slave RAM with wait states and ERR/RTY
//
// Purpose : Word-addressed, byte-writable scratch RAM on Wishbone. Each access
//           waits WAIT_STATES cycles, then terminates with exactly one of
//           ACK/ERR/RTY for one cycle.
// Ports   : wb_clk_i, wb_rst_i (sync, active-high),
//           wb_adr_i/wb_dat_i/wb_sel_i/wb_we_i/wb_cyc_i/wb_stb_i request,
//           wb_dat_o read data, wb_ack_o/wb_err_o/wb_rty_o terminations,
//           busy_i forces RTY when high at acceptance.
module wb_ram_slave #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  input  logic        busy_i
);

  import wb_ram_slave_pkg::*;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  state_e    state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic      busy_q, busy_d;
  logic      ack_q, ack_d;
  logic      err_q, err_d;
  logic      rty_q, rty_d;

  logic                  req;
  logic                  in_range;
  logic                  busy_now;
  logic                  enter_resp;
  term_e                 term;
  logic                  mem_we;
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] word_addr;

  assign req       = wb_cyc_i & wb_stb_i;
  assign word_addr = wb_adr_i[ADDR_WIDTH+1:2];
  // BASE_ADDR is aligned to the RAM size, so a range check is an upper-bit match.
  assign in_range  = (wb_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  // With zero wait states acceptance and classification share one edge,
  // so the live busy_i is used instead of the not-yet-loaded latch.
  assign busy_now  = (state_q == ST_IDLE) ? busy_i : busy_q;
  assign term      = classify(busy_now, in_range, wb_adr_i[1:0], wb_sel_i);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    enter_resp = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          cnt_d  = WAIT_CNT;
          busy_d = busy_i;
          if (WAIT_CNT == 4'd0) begin
            enter_resp = 1'b1;
            state_d    = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          // Abort: master withdrew, no termination and no write.
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          enter_resp = 1'b1;
          state_d    = ST_RESP;
          cnt_d      = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    ack_d = enter_resp && (term == TERM_ACK);
    err_d = enter_resp && (term == TERM_ERR);
    rty_d = enter_resp && (term == TERM_RTY);
  end

  // Reset at the commit edge drops the pending write.
  assign mem_we = ack_d && wb_we_i && !wb_rst_i;
  assign mem_re = ack_d && !wb_we_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
    end
  end

  wb_ram_slave_mem #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .addr_i  (word_addr),
    .we_i    (mem_we),
    .be_i    (wb_sel_i),
    .wdata_i (wb_dat_i),
    .re_i    (mem_re),
    .rdata_o (wb_dat_o)
  );

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = rty_q;

endmodule

// File: tb/tb_wb_ram_slave.sv
// tb/tb_wb_ram_slave.sv - self-checking bench for wb_ram_slave
module tb_wb_ram_slave;

  localparam int NDUT   = 4;
  localparam int T_NONE = 0;
  localparam int T_ACK  = 1;
  localparam int T_ERR  = 2;
  localparam int T_RTY  = 3;
  localparam int T_MULT = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = 32'h0;
  logic [31:0] wdat = 32'h0;
  logic [3:0]  sel = 4'h0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic        busy = 1'b0;
  logic [1:0]  dsel = 2'd0;

  logic [NDUT-1:0] ack_v, err_v, rty_v;
  logic [31:0]     dat_v [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance g has WAIT_STATES 1, 0, 3, 15; only the selected one sees cyc.
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    wb_ram_slave #(
      .ADDR_WIDTH (8),
      .BASE_ADDR  (32'h0000_0000),
      .WAIT_STATES((g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 15)
    ) u_dut (
      .wb_clk_i(clk),
      .wb_rst_i(rst),
      .wb_adr_i(adr),
      .wb_dat_i(wdat),
      .wb_dat_o(dat_v[g]),
      .wb_sel_i(sel),
      .wb_cyc_i(cyc && (dsel == 2'(g))),
      .wb_stb_i(stb),
      .wb_we_i (we),
      .wb_ack_o(ack_v[g]),
      .wb_err_o(err_v[g]),
      .wb_rty_o(rty_v[g]),
      .busy_i  (busy)
    );
  end

  function automatic int ws_of(input logic [1:0] d);
    case (d)
      2'd0:    return 1;
      2'd1:    return 0;
      2'd2:    return 3;
      default: return 15;
    endcase
  endfunction

  function automatic int term_now();
    int n;
    n = int'(ack_v[dsel]) + int'(err_v[dsel]) + int'(rty_v[dsel]);
    if (n > 1) return T_MULT;
    if (ack_v[dsel]) return T_ACK;
    if (err_v[dsel]) return T_ERR;
    if (rty_v[dsel]) return T_RTY;
    return T_NONE;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout waiting for termination", name);
  endtask

  typedef struct {
    int          term;
    logic [31:0] dat;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  // Drive one access on instance dsel; expectations go to the scoreboard on
  // drive and are popped when the termination pulse appears.
  task automatic access(input string name, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic b,
                        input int exp_term, input logic [31:0] exp_dat);
    exp_t e;
    exp_t x;
    int   t;
    bit   seen;
    e.term = exp_term;
    e.dat  = exp_dat;
    e.lat  = 1 + ws_of(dsel);
    e.name = name;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s; busy = b;
    sb_q.push_back(e);
    seen = 1'b0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(posedge clk); #1;
      t = term_now();
      if (t != T_NONE) begin
        seen = 1'b1;
        cyc = 1'b0; stb = 1'b0; busy = 1'b0;
        x = sb_q.pop_front();
        check({x.name, "_term"}, 32'(t), 32'(x.term));
        check({x.name, "_lat"}, 32'(n), 32'(x.lat));
        check({x.name, "_dat"}, dat_v[dsel], x.dat);
      end
    end
    if (!seen) begin
      cyc = 1'b0; stb = 1'b0; busy = 1'b0;
      x = sb_q.pop_front();
      timeout(x.name);
    end
  endtask

  // Reads with stb held high; ACK k (from 0) lands in cycle (k+1)*(2+ws)-1.
  task automatic b2b(input logic [1:0] d, input int nack);
    int got;
    int n;
    int t;
    got = 0;
    n = 0;
    dsel = d;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10; sel = 4'hF; busy = 1'b0;
    while (got < nack && n < 200) begin
      @(posedge clk); #1;
      n++;
      t = term_now();
      if (t != T_NONE) begin
        check($sformatf("b2b_d%0d_%0d_term", d, got), 32'(t), 32'(T_ACK));
        check($sformatf("b2b_d%0d_%0d_cycle", d, got), 32'(n),
              32'((got + 1) * (2 + ws_of(d)) - 1));
        got++;
      end
    end
    cyc = 1'b0; stb = 1'b0;
    if (got < nack) timeout($sformatf("b2b_d%0d", d));
  endtask

  typedef struct {
    logic [1:0]  d;
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  s;
    logic        b;
    int          term;
    logic [31:0] dat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] d, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] s, input logic b,
                     input int term, input logic [31:0] dat);
    vec_t v;
    v.d = d; v.w = w; v.a = a; v.wd = wd; v.s = s; v.b = b; v.term = term; v.dat = dat;
    vecs.push_back(v);
  endtask

  initial begin : main
    int cnt;

    //  dut  we    addr         wdata          sel   busy  term   wb_dat_o after
    add(0, 1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 1'b0, T_ACK, 32'h0);
    add(0, 1'b0, 32'h010, 32'h0,        4'hF, 1'b0, T_ACK, 32'hDEADBEEF);
    add(0, 1'b1, 32'h020, 32'h11223344, 4'hF, 1'b0, T_ACK, 32'hDEADBEEF);
    add(0, 1'b1, 32'h020, 32'hAABBCCDD, 4'h5, 1'b0, T_ACK, 32'hDEADBEEF);
    add(0, 1'b0, 32'h020, 32'h0,        4'hF, 1'b0, T_ACK, 32'h11BB33DD);
    add(0, 1'b0, 32'h400, 32'h0,        4'hF, 1'b0, T_ERR, 32'h11BB33DD);
    add(0, 1'b1, 32'h013, 32'h12345678, 4'hF, 1'b0, T_ERR, 32'h11BB33DD);
    add(0, 1'b0, 32'h010, 32'h0,        4'hF, 1'b0, T_ACK, 32'hDEADBEEF);
    add(0, 1'b0, 32'h020, 32'h0,        4'h0, 1'b0, T_ERR, 32'hDEADBEEF);
    add(0, 1'b0, 32'h020, 32'h0,        4'h1, 1'b0, T_ACK, 32'h11BB33DD);
    add(0, 1'b1, 32'h000, 32'h0,        4'hF, 1'b0, T_ACK, 32'h11BB33DD);
    add(0, 1'b1, 32'h000, 32'h5,        4'hF, 1'b1, T_RTY, 32'h11BB33DD);
    add(0, 1'b0, 32'h000, 32'h0,        4'hF, 1'b0, T_ACK, 32'h0);
    add(0, 1'b1, 32'h000, 32'h5,        4'hF, 1'b0, T_ACK, 32'h0);
    add(0, 1'b0, 32'h000, 32'h0,        4'hF, 1'b0, T_ACK, 32'h5);
    add(0, 1'b1, 32'h3FC, 32'h0BADC0DE, 4'hF, 1'b0, T_ACK, 32'h5);
    add(0, 1'b0, 32'h3FC, 32'h0,        4'hF, 1'b0, T_ACK, 32'h0BADC0DE);
    add(0, 1'b1, 32'h400, 32'h1,        4'hF, 1'b0, T_ERR, 32'h0BADC0DE);
    add(0, 1'b0, 32'h010, 32'h0,        4'hF, 1'b1, T_RTY, 32'h0BADC0DE);
    add(1, 1'b1, 32'h004, 32'hCAFEF00D, 4'hF, 1'b0, T_ACK, 32'h0);
    add(1, 1'b0, 32'h004, 32'h0,        4'hF, 1'b0, T_ACK, 32'hCAFEF00D);
    add(1, 1'b0, 32'h004, 32'h0,        4'hF, 1'b1, T_RTY, 32'hCAFEF00D);
    add(3, 1'b1, 32'h008, 32'h13579BDF, 4'hF, 1'b0, T_ACK, 32'h0);
    add(3, 1'b0, 32'h008, 32'h0,        4'hF, 1'b0, T_ACK, 32'h13579BDF);
    add(2, 1'b1, 32'h030, 32'h0,        4'hF, 1'b0, T_ACK, 32'h0);
    add(2, 1'b1, 32'h034, 32'h1,        4'hF, 1'b0, T_ACK, 32'h0);
    add(2, 1'b0, 32'h034, 32'h0,        4'hF, 1'b0, T_ACK, 32'h1);

    // Reset state of every instance.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      dsel = 2'(d);
      check($sformatf("reset_d%0d_term", d), 32'(term_now()), 32'(T_NONE));
      check($sformatf("reset_d%0d_dat", d), dat_v[d], 32'h0);
    end
    rst = 1'b0;

    foreach (vecs[i]) begin
      dsel = vecs[i].d;
      access($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].s,
             vecs[i].b, vecs[i].term, vecs[i].dat);
    end

    // Abort: WAIT_STATES=3, stb dropped in cycle 2 -> no termination, no write.
    dsel = 2'd2;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h30; wdat = 32'h99; sel = 4'hF; busy = 1'b0;
    cnt = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (term_now() != T_NONE) cnt++;
      if (n == 2) stb = 1'b0;
    end
    cyc = 1'b0;
    check("abort_noterm", 32'(cnt), 32'h0);
    access("abort_readback", 1'b0, 32'h30, 32'h0, 4'hF, 1'b0, T_ACK, 32'h0);
    access("pre_reset_read", 1'b0, 32'h34, 32'h0, 4'hF, 1'b0, T_ACK, 32'h1);

    // Back-to-back spacing with stb held high.
    b2b(2'd0, 3);
    b2b(2'd1, 3);

    // Reset on the edge that would commit a WAIT_STATES=3 write.
    dsel = 2'd2;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h34; wdat = 32'h77; sel = 4'hF; busy = 1'b0;
    cnt = 0;
    for (int n = 1; n <= 3; n++) begin
      @(posedge clk); #1;
      if (term_now() != T_NONE) cnt++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_term", 32'(term_now()), 32'(T_NONE));
    check("rst_mid_dat", dat_v[2], 32'h0);
    check("rst_mid_dat_d0", dat_v[0], 32'h0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
      if (term_now() != T_NONE) cnt++;
    end
    check("rst_mid_noterm", 32'(cnt), 32'h0);
    access("rst_write_dropped", 1'b0, 32'h34, 32'h0, 4'hF, 1'b0, T_ACK, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
